// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access unit.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWait,
    StWr,
    StResp
  } state_e;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Default number of WAIT cycles before a load is abandoned.
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // An access is misaligned when its offset is not a multiple of its size.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic mis;
    unique case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store mask/data placement and load extraction/extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [2:0]  st_off,
  input  logic [63:0] st_wdata,
  output logic [7:0]  st_mask,
  output logic [63:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic [2:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [63:0] ld_rdata,
  output logic [63:0] ld_data
);

  logic [7:0]  base_mask;
  logic [63:0] ld_shifted;

  // Store side: enable nbytes lanes starting at the offset and move data there.
  always_comb begin
    base_mask = 8'h00;
    unique case (st_size)
      SZ_B:    base_mask = 8'h01;
      SZ_H:    base_mask = 8'h03;
      SZ_W:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
    st_mask = base_mask << st_off;
    st_data = st_wdata << {st_off, 3'b000};
  end

  // Load side: right-align the addressed bytes, then zero- or sign-extend.
  always_comb begin
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    ld_data    = 64'h0;
    unique case (ld_size)
      SZ_B: ld_data = ld_unsigned ? {56'h0, ld_shifted[7:0]}
                                  : {{56{ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_H: ld_data = ld_unsigned ? {48'h0, ld_shifted[15:0]}
                                  : {{48{ld_shifted[15]}}, ld_shifted[15:0]};
      SZ_W: ld_data = ld_unsigned ? {32'h0, ld_shifted[31:0]}
                                  : {{32{ld_shifted[31]}}, ld_shifted[31:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between a CPU port and a 64-bit memory.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  input  logic [63:0] mem_rData,
  input  logic        mem_rvalid,
  input  logic        mem_hit,
  output logic        mem_wen,
  output logic [63:0] mem_wData,
  output logic [7:0]  mem_wMask
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  logic [7:0]  st_mask;
  logic [63:0] st_data;
  logic [63:0] ld_data;

  // Store lanes come from the live request so they can be captured at acceptance;
  // load extraction uses the latched request.
  mem_lane_align u_lane_align (
    .st_size     (req_size),
    .st_off      (req_addr[2:0]),
    .st_wdata    (req_wdata),
    .st_mask     (st_mask),
    .st_data     (st_data),
    .ld_size     (size_q),
    .ld_off      (addr_q[2:0]),
    .ld_unsigned (unsigned_q),
    .ld_rdata    (mem_rData),
    .ld_data     (ld_data)
  );

  // Next-state logic: request acceptance, WAIT timeout and response capture.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d     = req_addr;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          wmask_d    = st_mask;
          wdata_d    = st_data;
          rdata_d    = 64'h0;
          err_d      = 1'b0;
          wait_cnt_d = 32'd0;
          if (is_misaligned(req_addr[2:0], req_size)) begin
            state_d = StResp;
            err_d   = 1'b1;
          end else if (req_wen) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        state_d    = StWait;
        wait_cnt_d = 32'd0;
      end
      StWait: begin
        if (mem_rvalid) begin
          state_d = StResp;
          err_d   = !mem_hit;
          rdata_d = mem_hit ? ld_data : 64'h0;
        end else if (wait_cnt_q + 32'd1 >= TIMEOUT) begin
          state_d = StResp;
          err_d   = 1'b1;
          rdata_d = 64'h0;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      StWr: begin
        state_d = StResp;
        err_d   = 1'b0;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; synchronous reset wins over any request in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= 32'h0;
      size_q     <= SZ_B;
      unsigned_q <= 1'b0;
      wmask_q    <= 8'h0;
      wdata_q    <= 64'h0;
      rdata_q    <= 64'h0;
      err_q      <= 1'b0;
      wait_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Outputs decode directly from registered state and latched fields.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_rdata = resp_valid ? rdata_q : 64'h0;
    resp_err   = resp_valid ? err_q : 1'b0;
    mem_ren    = (state_q == StRd);
    mem_wen    = (state_q == StWr);
    mem_addr   = {addr_q[31:3], 3'b000};
    mem_wData  = wdata_q;
    mem_wMask  = wmask_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT=4).
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [63:0] mem_rData;
  logic        mem_rvalid;
  logic        mem_hit;
  logic        mem_wen;
  logic [63:0] mem_wData;
  logic [7:0]  mem_wMask;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_ren      (mem_ren),
    .mem_addr     (mem_addr),
    .mem_rData    (mem_rData),
    .mem_rvalid   (mem_rvalid),
    .mem_hit      (mem_hit),
    .mem_wen      (mem_wen),
    .mem_wData    (mem_wData),
    .mem_wMask    (mem_wMask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample point is 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one edge; returns in cycle A+1.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata);
    check_eq("ready_before_issue", 64'(req_ready), 64'd1);
    req_wen      = wen;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    tick();
    req_valid    = 1'b0;
  endtask

  // Load with memory answering one cycle after mem_ren; checks the A+3 response.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] data, input logic hit,
                         input logic [63:0] exp_rdata, input logic exp_err);
    issue(1'b0, addr, size, uns, 64'h0);
    check_eq({tag, "_ren_a1"}, 64'(mem_ren), 64'd1);
    check_eq({tag, "_addr_a1"}, 64'(mem_addr), 64'(addr & 32'hFFFF_FFF8));
    tick();
    check_eq({tag, "_ren_a2"}, 64'(mem_ren), 64'd0);
    mem_rvalid = 1'b1;
    mem_rData  = data;
    mem_hit    = hit;
    tick();
    mem_rvalid = 1'b0;
    mem_rData  = 64'h0;
    check_eq({tag, "_valid_a3"}, 64'(resp_valid), 64'd1);
    check_eq({tag, "_rdata_a3"}, resp_rdata, exp_rdata);
    check_eq({tag, "_err_a3"}, 64'(resp_err), 64'(exp_err));
    tick();
    check_eq({tag, "_valid_after"}, 64'(resp_valid), 64'd0);
  endtask

  // Store; checks lanes in A+1 and the response in A+2.
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [63:0] wdata, input logic [7:0] exp_mask,
                          input logic [63:0] exp_data);
    issue(1'b1, addr, size, 1'b0, wdata);
    check_eq({tag, "_wen_a1"}, 64'(mem_wen), 64'd1);
    check_eq({tag, "_ren_a1"}, 64'(mem_ren), 64'd0);
    check_eq({tag, "_addr_a1"}, 64'(mem_addr), 64'(addr & 32'hFFFF_FFF8));
    check_eq({tag, "_mask_a1"}, 64'(mem_wMask), 64'(exp_mask));
    check_eq({tag, "_wdata_a1"}, mem_wData, exp_data);
    check_eq({tag, "_valid_a1"}, 64'(resp_valid), 64'd0);
    tick();
    check_eq({tag, "_wen_a2"}, 64'(mem_wen), 64'd0);
    check_eq({tag, "_valid_a2"}, 64'(resp_valid), 64'd1);
    check_eq({tag, "_err_a2"}, 64'(resp_err), 64'd0);
    check_eq({tag, "_rdata_a2"}, resp_rdata, 64'h0);
    tick();
    check_eq({tag, "_valid_a3"}, 64'(resp_valid), 64'd0);
    check_eq({tag, "_mask_held"}, 64'(mem_wMask), 64'(exp_mask));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b1;  // request during reset must be ignored
    req_wen      = 1'b1;
    req_addr     = 32'h8000_0004;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_wdata    = 64'hFFFF_FFFF;
    mem_rData    = 64'h0;
    mem_rvalid   = 1'b0;
    mem_hit      = 1'b0;
    tick();
    tick();
    check_eq("rst_ready", 64'(req_ready), 64'd1);
    check_eq("rst_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_rdata", resp_rdata, 64'h0);
    check_eq("rst_err", 64'(resp_err), 64'd0);
    check_eq("rst_ren", 64'(mem_ren), 64'd0);
    check_eq("rst_wen", 64'(mem_wen), 64'd0);
    check_eq("rst_addr", 64'(mem_addr), 64'h0);
    check_eq("rst_wdata", mem_wData, 64'h0);
    check_eq("rst_mask", 64'(mem_wMask), 64'h0);
    reset     = 1'b0;
    req_valid = 1'b0;
    tick();
    check_eq("post_rst_ready", 64'(req_ready), 64'd1);
    check_eq("post_rst_wen", 64'(mem_wen), 64'd0);

    // Stores
    do_store("st_word", 32'h8000_0004, 2'd2, 64'h1122_3344, 8'hF0, 64'h1122_3344_0000_0000);
    do_store("st_byte7", 32'h8000_0007, 2'd0, 64'h0000_00AB, 8'h80, 64'hAB00_0000_0000_0000);
    do_store("st_dbl", 32'h8000_0008, 2'd3, 64'h0123_4567_89AB_CDEF, 8'hFF,
             64'h0123_4567_89AB_CDEF);
    do_store("st_half2", 32'h8000_0002, 2'd1, 64'hFFFF_FFFF_FFFF_BEEF, 8'h0C,
             64'hFFFF_FFFF_BEEF_0000);

    // Loads
    do_load("ld_sb", 32'h8000_0003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 1'b1,
            64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    do_load("ld_ub", 32'h8000_0003, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 1'b1,
            64'h0000_0000_0000_0080, 1'b0);
    do_load("ld_sh6", 32'h8000_0006, 2'd1, 1'b0, 64'hBEEF_0000_0000_0000, 1'b1,
            64'hFFFF_FFFF_FFFF_BEEF, 1'b0);
    do_load("ld_sw4", 32'h8000_0004, 2'd2, 1'b0, 64'h7654_3210_DEAD_BEEF, 1'b1,
            64'h0000_0000_7654_3210, 1'b0);
    do_load("ld_uw0", 32'h8000_0000, 2'd2, 1'b1, 64'h7654_3210_DEAD_BEEF, 1'b1,
            64'h0000_0000_DEAD_BEEF, 1'b0);
    do_load("ld_dbl_u", 32'h8000_0008, 2'd3, 1'b0, 64'h8123_4567_89AB_CDEF, 1'b1,
            64'h8123_4567_89AB_CDEF, 1'b0);
    do_load("ld_dbl_miss", 32'h8000_0008, 2'd3, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0,
            64'h0, 1'b1);

    // Misaligned half: immediate error, no strobes
    issue(1'b0, 32'h8000_0001, 2'd1, 1'b0, 64'h0);
    check_eq("mis_valid_a1", 64'(resp_valid), 64'd1);
    check_eq("mis_err_a1", 64'(resp_err), 64'd1);
    check_eq("mis_rdata_a1", resp_rdata, 64'h0);
    check_eq("mis_ren_a1", 64'(mem_ren), 64'd0);
    check_eq("mis_wen_a1", 64'(mem_wen), 64'd0);
    tick();
    check_eq("mis_valid_a2", 64'(resp_valid), 64'd0);
    check_eq("mis_ready_a2", 64'(req_ready), 64'd1);

    // Misaligned store word: also no strobe
    issue(1'b1, 32'h8000_0006, 2'd2, 1'b0, 64'h55);
    check_eq("mis_st_wen_a1", 64'(mem_wen), 64'd0);
    check_eq("mis_st_err_a1", 64'(resp_err), 64'd1);
    tick();

    // Timeout: WAIT in A+2..A+5, error response in A+6
    issue(1'b0, 32'h8000_0010, 2'd2, 1'b0, 64'h0);
    check_eq("to_ren_a1", 64'(mem_ren), 64'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("to_valid_a%0d", i + 2), 64'(resp_valid), 64'd0);
      check_eq($sformatf("to_ready_a%0d", i + 2), 64'(req_ready), 64'd0);
      tick();
    end
    check_eq("to_valid_a6", 64'(resp_valid), 64'd1);
    check_eq("to_err_a6", 64'(resp_err), 64'd1);
    check_eq("to_rdata_a6", resp_rdata, 64'h0);
    tick();
    check_eq("to_valid_a7", 64'(resp_valid), 64'd0);

    // Reset while in WAIT, then a late mem_rvalid must be ignored
    issue(1'b0, 32'h8000_0020, 2'd2, 1'b0, 64'h0);
    tick();
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rData  = 64'h1111_2222_3333_4444;
    mem_hit    = 1'b1;
    tick();
    check_eq("rw_ready", 64'(req_ready), 64'd1);
    check_eq("rw_valid", 64'(resp_valid), 64'd0);
    mem_rvalid = 1'b0;
    tick();
    check_eq("rw_valid2", 64'(resp_valid), 64'd0);
    check_eq("rw_ren", 64'(mem_ren), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
